// File: rtl/dram_arbiter.sv
// Two-requester (ifu/lsu) arbiter in front of a single-port data RAM, with at most one read outstanding.
// Define DRAM_ARB_RR_EN for round-robin arbitration; the default is fixed priority with lsu over ifu.
module dram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            ifu_req,
  input  logic [AW-1:0]   ifu_addr,
  input  logic            ifu_flush,
  output logic            ifu_gnt,
  output logic            ifu_rvalid,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req,
  input  logic            lsu_write,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            ram_req,
  output logic            ram_write,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_wstrb,
  input  logic            ram_ready,
  input  logic            ram_rvalid,
  input  logic [DW-1:0]   ram_rdata
);
  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t state;
  logic   owner;   // 0 = ifu, 1 = lsu
  logic   drop;
  logic   sel_lsu, gnt, rd_gnt, rsp;

`ifdef DRAM_ARB_RR_EN
  logic rr_ptr;    // last granted port; the other one wins the next contested cycle
  assign sel_lsu = lsu_req & (~ifu_req | ~rr_ptr);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   rr_ptr <= 1'b0;
    else if (gnt) rr_ptr <= sel_lsu;
  end
`else
  assign sel_lsu = lsu_req;
`endif

  assign ram_req   = rst_b & (state == IDLE) & (ifu_req | lsu_req);
  assign gnt       = ram_req & ram_ready;
  assign lsu_gnt   = gnt & sel_lsu;
  assign ifu_gnt   = gnt & ~sel_lsu;
  assign rd_gnt    = gnt & ~(sel_lsu & lsu_write);

  assign ram_write = sel_lsu & lsu_write;
  assign ram_addr  = sel_lsu ? lsu_addr  : ifu_addr;
  assign ram_wdata = sel_lsu ? lsu_wdata : '0;
  assign ram_wstrb = sel_lsu ? lsu_wstrb : '0;

  // Data is a straight pass-through; only the strobes are steered to the owner.
  assign rsp        = rst_b & (state == RD_WAIT) & ram_rvalid;
  assign lsu_rvalid = rsp & owner;
  assign ifu_rvalid = rsp & ~owner & ~drop & ~ifu_flush;
  assign ifu_rdata  = ram_rdata;
  assign lsu_rdata  = ram_rdata;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      owner <= 1'b0;
      drop  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rd_gnt) begin
          state <= RD_WAIT;
          owner <= sel_lsu;
          drop  <= ~sel_lsu & ifu_flush;
        end
        RD_WAIT: begin
          if (ifu_flush && !owner) drop <= 1'b1;
          if (ram_rvalid) begin
            state <= IDLE;
            drop  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width; byte-strobe width is DW/8.
REQ-003 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_b  in  1  asynchronous, active-low reset.
REQ-005 ifu_req  in  1 / ifu_addr  in  AW  instruction-fetch read request and its address.
REQ-006 ifu_flush  in  1  kill any outstanding instruction-fetch read.
REQ-007 ifu_gnt  out  1 / ifu_rvalid  out  1 / ifu_rdata  out  DW  instruction-fetch accept, read-response strobe and read data.
REQ-008 lsu_req  in  1 / lsu_write  in  1 / lsu_addr  in  AW / lsu_wdata  in  DW / lsu_wstrb  in  DW/8  load/store request.
REQ-009 lsu_gnt  out  1 / lsu_rvalid  out  1 / lsu_rdata  out  DW  load/store accept, load-response strobe and load data.
REQ-010 ram_req  out  1 / ram_write  out  1 / ram_addr  out  AW / ram_wdata  out  DW / ram_wstrb  out  DW/8  single-port data RAM command.
REQ-011 ram_ready  in  1 / ram_rvalid  in  1 / ram_rdata  in  DW  RAM command accept, read-response strobe and read data.

Function
REQ-012 Two-state FSM: IDLE, RD_WAIT; at most one read outstanding.
REQ-013 IDLE: ram_req = ifu_req | lsu_req; the command fields SHALL be muxed from the selected requester.
REQ-014 ifu requests SHALL drive ram_write=0 and ram_wstrb=0.
REQ-015 Grant SHALL be combinational: sel_gnt = ram_req & ram_ready & selected. A requester SHALL be held until its gnt.
REQ-016 Granted read: go to RD_WAIT the next cycle and register owner (0=ifu, 1=lsu).
REQ-017 Granted write: stay in IDLE; a new command is allowed the next cycle; no response is returned.
REQ-018 RD_WAIT: ram_req=0 and both gnt=0.
- On ram_rvalid: route ram_rdata to the owner's rdata and pulse the owner's rvalid in the same cycle (0-cycle pass-through).
- Return to IDLE the next cycle.
REQ-019 ifu_rdata and lsu_rdata SHALL always equal ram_rdata; only the rvalid strobes are gated.
REQ-020 An ifu_flush asserted in RD_WAIT with owner=ifu, or in the cycle ifu_gnt fires, SHALL set a drop flag.
- The matching ram_rvalid is consumed, ifu_rvalid stays 0, and the drop flag clears on leaving RD_WAIT.
REQ-021 ifu_flush SHALL NOT affect an lsu-owned read.
REQ-022 ram_rvalid in IDLE (spurious) SHALL be ignored: both rvalid=0.
REQ-023 Simultaneous ifu_req and lsu_req: arbitration per REQ-027/028; the loser's gnt=0.

Reset
REQ-024 Asserting rst_b low SHALL force, asynchronously: state=IDLE, owner=0, drop flag=0, round-robin pointer=0.
REQ-025 While rst_b is low: ram_req=0, ifu_gnt=0, lsu_gnt=0, ifu_rvalid=0, lsu_rvalid=0.
REQ-026 Reset during RD_WAIT SHALL abandon the read; a ram_rvalid arriving after reset release is ignored per REQ-022.

Configuration
REQ-027 DRAM_ARB_RR_EN undefined: fixed priority, lsu over ifu.
REQ-028 DRAM_ARB_RR_EN defined: 1-bit last-grant pointer, reset value 0 (lsu favoured first).
- On each grant the pointer is set to the granted port; the next contested cycle favours the other port.
- Uncontested requests are granted regardless of the pointer.

Verification
REQ-029 lsu load to 0x100, ram_ready=1, ram_rvalid 2 cycles later with 0xDEADBEEF -> lsu_gnt pulse, lsu_rvalid=1 with lsu_rdata=0xDEADBEEF, ifu_rvalid=0.
REQ-030 ifu_req and lsu_req (store, wstrb=0xF) both held 4 cycles, ram_ready=1:
- Without DRAM_ARB_RR_EN: lsu granted first, ifu granted only after lsu drops.
- With DRAM_ARB_RR_EN and both reissuing: grants alternate lsu, ifu, lsu, ...
REQ-031 ifu read granted, ifu_flush pulsed in RD_WAIT, ram_rvalid 3 cycles later -> ifu_rvalid stays 0; the next ifu read returns normally.
REQ-032 ram_ready=0 for 5 cycles with lsu_req held -> lsu_gnt=0 and the command is stable; ram_ready=1 -> single grant.
REQ-033 Three back-to-back stores -> one grant per cycle, FSM stays IDLE, no rvalid.
REQ-034 rst_b low mid-RD_WAIT, late ram_rvalid after release -> both rvalid=0, FSM in IDLE.
